// File: rtl/readout_pkg.sv
// Shared types and constants for the readout token scheduler.
package readout_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StGrant,
        StDone
    } state_e;

    localparam int unsigned CH_IDX_W    = 5;
    localparam int unsigned PTR_W       = CH_IDX_W + 1;
    localparam int unsigned DEF_PERIOD  = 60000;
    localparam int unsigned DEF_TIMEOUT = 1024;

endpackage

// File: rtl/readout_next_sel.sv
// Picks the lowest set mask bit at or above ptr_i; found_o low when none remain.
module readout_next_sel
    import readout_pkg::*;
#(
    parameter int unsigned NUM_CH = 17
) (
    input  logic [NUM_CH-1:0]   mask_i,
    input  logic [PTR_W-1:0]    ptr_i,
    output logic [CH_IDX_W-1:0] sel_o,
    output logic                found_o
);

    logic [NUM_CH-1:0] cand;

    always_comb begin
        cand    = '0;
        sel_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i] = mask_i[i] && (i >= int'(ptr_i));
        end
        // Descending walk so the lowest candidate is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_o   = CH_IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/readout_token_scheduler.sv
// Scans enabled readout channels in ascending order, granting one token at a time.
// Define READOUT_DEAD_MASK_EN to skip channels that have ever timed out.
module readout_token_scheduler
    import readout_pkg::*;
#(
    parameter int unsigned NUM_CH   = 17,
    parameter int unsigned PERIOD_W = 33,
    parameter int unsigned PERIOD   = DEF_PERIOD,
    parameter int unsigned TO_W     = 16,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [NUM_CH-1:0]   ch_en_i,
    input  logic [NUM_CH-1:0]   TokenReady_i,
    output logic [NUM_CH-1:0]   TokenValid_o,
    output logic                busy_o,
    output logic [CH_IDX_W-1:0] cur_ch_o,
    output logic                scan_done_o,
    output logic                timeout_o,
    output logic [CH_IDX_W-1:0] timeout_ch_o,
    output logic [NUM_CH-1:0]   dead_mask_o
);

    state_e                state_q;
    logic [PERIOD_W-1:0]   slack_q;
    logic [TO_W-1:0]       to_cnt_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [NUM_CH-1:0]     en_q;
    logic [CH_IDX_W-1:0]   cur_q;
    logic [CH_IDX_W-1:0]   timeout_ch_q;
    logic [NUM_CH-1:0]     tv_q;
    logic                  busy_q;
    logic                  scan_done_q;
    logic                  timeout_q;
    logic [NUM_CH-1:0]     scan_mask;
    logic [CH_IDX_W-1:0]   sel;
    logic                  found;

`ifdef READOUT_DEAD_MASK_EN
    logic [NUM_CH-1:0] dead_q;
    assign scan_mask   = en_q & ~dead_q;
    assign dead_mask_o = dead_q;
`else
    assign scan_mask   = en_q;
    assign dead_mask_o = '0;
`endif

    readout_next_sel #(
        .NUM_CH (NUM_CH)
    ) u_next_sel (
        .mask_i  (scan_mask),
        .ptr_i   (ptr_q),
        .sel_o   (sel),
        .found_o (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            slack_q      <= '0;
            to_cnt_q     <= '0;
            ptr_q        <= '0;
            en_q         <= '0;
            cur_q        <= '0;
            timeout_ch_q <= '0;
            tv_q         <= '0;
            busy_q       <= 1'b0;
            scan_done_q  <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef READOUT_DEAD_MASK_EN
            dead_q       <= '0;
`endif
        end else begin
            scan_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i || (slack_q == PERIOD_W'(PERIOD - 1))) begin
                        state_q <= StScan;
                        slack_q <= '0;
                        ptr_q   <= '0;
                        en_q    <= ch_en_i;
                        busy_q  <= 1'b1;
                    end else begin
                        slack_q <= slack_q + PERIOD_W'(1);
                    end
                end
                StScan: begin
                    if (found) begin
                        state_q  <= StGrant;
                        cur_q    <= sel;
                        to_cnt_q <= '0;
                        tv_q     <= NUM_CH'(1) << sel;
                    end else begin
                        state_q     <= StDone;
                        scan_done_q <= 1'b1;
                    end
                end
                StGrant: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    // Ready has priority over a coincident timeout.
                    if (TokenReady_i[cur_q]) begin
                        state_q <= StScan;
                        ptr_q   <= PTR_W'(cur_q) + PTR_W'(1);
                        tv_q    <= '0;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_q      <= StScan;
                        ptr_q        <= PTR_W'(cur_q) + PTR_W'(1);
                        tv_q         <= '0;
                        timeout_q    <= 1'b1;
                        timeout_ch_q <= cur_q;
`ifdef READOUT_DEAD_MASK_EN
                        dead_q[cur_q] <= 1'b1;
`endif
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TokenValid_o = tv_q;
    assign busy_o       = busy_q;
    assign cur_ch_o     = cur_q;
    assign scan_done_o  = scan_done_q;
    assign timeout_o    = timeout_q;
    assign timeout_ch_o = timeout_ch_q;

endmodule
